// File: rtl/unary_rate_acc.sv
// Unary-rate column decoder: counts a product bitstream over a rate window and adds it to a partial sum.
// Optional macro UNARY_ACC_EARLY_TERM_EN adds i_len for a per-window length of i_len+1 bits.
module unary_rate_acc #(
   parameter int WIDTH  = 16,
   parameter int CWIDTH = WIDTH - 1,
   parameter int OWIDTH = 2 * WIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [OWIDTH-1:0] i_psum,
   input  logic              i_en,
   input  logic              i_bit,
   input  logic              i_ready,
`ifdef UNARY_ACC_EARLY_TERM_EN
   input  logic [CWIDTH-1:0] i_len,
`endif
   output logic              o_busy,
   output logic              o_valid,
   output logic [OWIDTH-1:0] o_sum
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_reg, state_next;
   logic [OWIDTH-1:0] acc_reg, acc_next;
   logic [CWIDTH-1:0] cnt_reg, cnt_next;
   logic              last_bit;
   logic              load;

`ifdef UNARY_ACC_EARLY_TERM_EN
   logic [CWIDTH-1:0] len_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_reg <= '0;
      end else if (load) begin
         len_reg <= i_len;
      end
   end

   assign last_bit = (cnt_reg == len_reg);
`else
   assign last_bit = (cnt_reg == {CWIDTH{1'b1}});
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      load       = 1'b0;
      case (state_reg)
         IDLE: begin
            load = i_start;
         end
         RUN: begin
            // Stalled cycles (i_en low) hold both the sum and the bit count.
            if (i_en) begin
               acc_next = acc_reg + {{(OWIDTH-1){1'b0}}, i_bit};
               cnt_next = cnt_reg + {{(CWIDTH-1){1'b0}}, 1'b1};
               if (last_bit) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            // A start is only honoured together with the handshake, giving back-to-back windows.
            if (i_ready) begin
               state_next = IDLE;
               load       = i_start;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (load) begin
         acc_next   = i_psum;
         cnt_next   = '0;
         state_next = RUN;
      end
   end

   assign o_busy  = (state_reg == RUN);
   assign o_valid = (state_reg == DONE);
   assign o_sum   = acc_reg;

endmodule

// File: doc/unary_rate_acc.md
Name: unary_rate_acc

Overview:
- Decoder at the output end of a unary-rate multiplier column: counts the product bitstream, one bit per cycle, over a fixed rate window.
- Adds the count to an incoming binary partial sum and presents the binary result with a valid/ready handshake.
- Sits below the systolic multiplier array; one instance per column converts the unary product back to binary for the next accumulation stage.

Parameters:
- WIDTH, 16, data width of the multiplier cells feeding the column.
- CWIDTH, WIDTH-1, log2 of the rate window length; window N = 2^CWIDTH bits.
- OWIDTH, 2*WIDTH, width of the partial-sum input and the result.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- i_start  input  1  begin a window; samples i_psum.
- i_psum  input  OWIDTH  partial sum loaded as the accumulator start value.
- i_en  input  1  stream-bit valid; bit sampled and window counter advanced only when high.
- i_bit  input  1  product bitstream from the column's multiplier cells.
- i_ready  input  1  downstream accepts o_sum.
- o_busy  output  1  window in progress (state RUN).
- o_valid  output  1  o_sum holds a finished result (state DONE).
- o_sum  output  OWIDTH  accumulated result.

Behaviour:
- States: IDLE, RUN, DONE. Internal registers: acc[OWIDTH], cnt[CWIDTH], FSM state.
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, cnt=0; o_busy=0, o_valid=0, o_sum=0.
- IDLE, i_start=1: acc<=i_psum, cnt<=0, go to RUN. The start cycle samples no bit.
- RUN, i_en=1: acc<=acc+i_bit (mod 2^OWIDTH, wraps silently); cnt<=cnt+1.
- RUN, i_en=1 and cnt==N-1: that final bit is added and state goes to DONE. Exactly N enabled bits are summed per window.
- RUN, i_en=0: acc and cnt hold (stall); no cycle limit.
- i_start while in RUN is ignored; the window is not restarted.
- DONE: o_valid=1. o_sum=acc, stable until the handshake completes.
  - i_ready=1 and i_start=0: go to IDLE.
  - i_ready=1 and i_start=1: result accepted and the new window loaded in the same cycle (acc<=i_psum, cnt<=0, go to RUN). No bubble.
  - i_ready=0: hold DONE; i_start ignored.
- IDLE, i_ready=1 with i_start=0: no effect.
- o_sum is driven from acc at all times. Only the DONE value is meaningful.
- Latency: o_valid rises the cycle after the Nth enabled bit. With i_en held high, that is N+1 cycles after the i_start cycle.
- Reset mid-RUN or mid-DONE: result discarded, return to IDLE.

Optional Feature:
- Macro: UNARY_ACC_EARLY_TERM_EN.
- Defined:
  - Adds input port i_len [CWIDTH-1:0], sampled together with i_start into a length register.
  - Window length becomes i_len+1 enabled bits (range 1..N); the terminal condition is cnt==len_reg.
  - A start accepted from DONE samples i_len in that same cycle.
- Undefined: port i_len absent; window fixed at N = 2^CWIDTH; no length register.

Test Plan:
- Bench uses CWIDTH=4 (N=16), OWIDTH=8.
- Reset, then i_start with i_psum=5, i_en=1, i_bit=1 for 16 cycles -> o_valid rises exactly 17 cycles after the start cycle, o_sum=21, o_busy low in DONE.
- i_psum=0, i_bit alternating 1/0 over 16 bits, with i_en deasserted for 3 random cycles mid-window -> o_sum=8; o_valid delayed by exactly 3 cycles versus the no-stall run.
- i_psum=250, all ones -> o_sum=10 (wrap mod 256). i_ready held low 5 cycles -> o_valid and o_sum stable throughout; i_start pulses during the hold ignored.
- Back-to-back: in DONE assert i_ready=1 and i_start=1 with i_psum=3, then all zeros -> first result consumed, no IDLE cycle; second o_sum=3.
- rst_n pulled low asynchronously at bit 9 of a window -> outputs 0 immediately, state IDLE; next start gives a correct fresh result.
- With UNARY_ACC_EARLY_TERM_EN, i_len=3, i_psum=0, all ones -> o_sum=4, o_valid 5 cycles after start; i_len=15 gives the same result as the non-macro build.
